// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the framebuffer arbiter and the 800x600@56 timing generator.
package vga_fb_pkg;

  typedef enum logic {IDLE, FETCH} fb_state_t;

  localparam int FB_ADDR_W     = 16;
  localparam int FB_DATA_W     = 8;
  localparam int FB_LINE_WORDS = 800;

  // 800x600@56 horizontal and vertical timing, in pixels and lines
  localparam int H_ACTIVE = 800;
  localparam int H_FRONT  = 24;
  localparam int H_SYNC   = 72;
  localparam int H_BACK   = 128;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_ACTIVE = 600;
  localparam int V_FRONT  = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 22;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  function automatic logic [7:0] rgb332(input logic [2:0] r, input logic [2:0] g,
                                        input logic [1:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_pix_fifo.sv
// Prefetch FIFO: storage array plus a registered head word (show-ahead output stage).
module pix_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [LVL_W-1:0]  level,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  cnt;
  logic              head_valid;
  logic              load;
  logic              pop_eff;

  // Head register refills whenever it is free or being popped this cycle
  assign load    = (cnt != '0) && (!head_valid || pop);
  assign pop_eff = pop && head_valid;
  assign level   = cnt + LVL_W'(head_valid);
  assign empty   = !head_valid;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      head_valid <= 1'b0;
      dout       <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        dout       <= mem[rd_ptr];
        head_valid <= 1'b1;
      end else if (pop_eff) begin
        head_valid <= 1'b0;
      end
      cnt <= cnt + LVL_W'(push) - LVL_W'(load);
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates a single-port framebuffer between line prefetch for scan-out and host writes.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int LINE_WORDS = FB_LINE_WORDS,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underrun,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = LVL_W + 1;
  localparam int REM_W = $clog2(LINE_WORDS + 1);

  fb_state_t         state;
  fb_state_t         state_next;
  logic [ADDR_W-1:0] fetch_addr;
  logic [REM_W-1:0]  remain;
  logic [LVL_W-1:0]  level;
  logic [OCC_W-1:0]  occ;
  logic              fifo_empty;
  logic              fetching;
  logic              grant_rd;
  logic              grant_wr;

  pix_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (mem_re && !line_start),
    .pop   (pix_rd),
    .flush (line_start),
    .din   (mem_rdata),
    .dout  (pix_data),
    .level (level),
    .empty (fifo_empty)
  );

  assign pix_valid = !fifo_empty;
  // A registered mem_re means that word lands next edge, so count it as occupied
  assign occ       = OCC_W'(level) + OCC_W'(mem_re);
  assign fetching  = (state == FETCH) && !line_start;

  always_comb begin
    state_next = state;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    if (fetching && (occ < OCC_W'(LOW_WATER))) begin
      grant_rd = 1'b1;
    end else if (wr_req && !wr_ack) begin
      grant_wr = 1'b1;
    end else if (fetching && (occ < OCC_W'(FIFO_DEPTH))) begin
      grant_rd = 1'b1;
    end
    if (line_start) begin
      state_next = FETCH;
    end else if (grant_rd && (remain == REM_W'(1))) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_addr <= '0;
      remain     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      wr_ack     <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state  <= state_next;
      mem_re <= grant_rd;
      mem_we <= grant_wr;
      wr_ack <= grant_wr;
      if (line_start) begin
        fetch_addr <= line_base;
        remain     <= REM_W'(LINE_WORDS);
      end else if (grant_rd) begin
        fetch_addr <= fetch_addr + ADDR_W'(1);
        remain     <= remain - REM_W'(1);
      end
      if (grant_rd) begin
        mem_addr <= fetch_addr;
      end else if (grant_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
      if (line_start) begin
        underrun <= 1'b0;
      end else if (pix_rd && fifo_empty) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter; memory returns the low byte of the read address.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [15:0] line_base = '0;
  logic        pix_rd = 1'b0;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        underrun;
  logic        wr_req = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr[7:0];

  vga_fb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .line_base  (line_base),
    .pix_rd     (pix_rd),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .underrun   (underrun),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_line(input logic [15:0] base);
    line_start = 1'b1;
    line_base  = base;
    tick();
    line_start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_pix_data", 32'(pix_data), 32'h0);
    chk("rst_pix_valid", 32'(pix_valid), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_wr_ack", 32'(wr_ack), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_re", 32'(mem_re), 32'h0);
    rst_n = 1'b1;
    tick();
    $display("reset released");

    // Full line streaming from 0x0100
    start_line(16'h0100);
    chk("l1_e0_re", 32'(mem_re), 32'h0);
    tick();
    chk("l1_e1_re", 32'(mem_re), 32'h1);
    chk("l1_e1_addr", 32'(mem_addr), 32'h0100);
    tick();
    chk("l1_e2_valid", 32'(pix_valid), 32'h0);
    tick();
    chk("l1_e3_valid", 32'(pix_valid), 32'h1);
    chk("l1_e3_data", 32'(pix_data), 32'h00);
    pix_rd = 1'b1;
    for (int i = 0; i < 800; i++) begin
      chk("l1_pop_valid", 32'(pix_valid), 32'h1);
      chk("l1_pop_data", 32'(pix_data), 32'(i % 256));
      tick();
    end
    pix_rd = 1'b0;
    chk("l1_underrun", 32'(underrun), 32'h0);
    chk("l1_end_valid", 32'(pix_valid), 32'h0);
    chk("l1_end_re", 32'(mem_re), 32'h0);
    $display("line 1: 800 pops from base 0100");

    // Underrun on an empty FIFO is sticky until line_start
    pix_rd = 1'b1;
    tick();
    pix_rd = 1'b0;
    chk("ur_set", 32'(underrun), 32'h1);
    tick(); tick();
    chk("ur_sticky", 32'(underrun), 32'h1);
    $display("underrun set by pop on empty FIFO");

    // Address wrap and FIFO fill with no pops
    start_line(16'hFFFE);
    chk("ur_cleared", 32'(underrun), 32'h0);
    tick();
    chk("wrap_a0", 32'(mem_addr), 32'hFFFE);
    tick();
    chk("wrap_a1", 32'(mem_addr), 32'hFFFF);
    tick();
    chk("wrap_a2", 32'(mem_addr), 32'h0000);
    tick();
    chk("wrap_a3", 32'(mem_addr), 32'h0001);
    for (int i = 0; i < 30; i++) tick();
    chk("full_re", 32'(mem_re), 32'h0);
    chk("full_valid", 32'(pix_valid), 32'h1);
    chk("full_data", 32'(pix_data), 32'hFE);
    pix_rd = 1'b1;
    tick();
    pix_rd = 1'b0;
    chk("pop1_re", 32'(mem_re), 32'h0);
    chk("pop1_data", 32'(pix_data), 32'hFF);
    tick();
    chk("resume_re", 32'(mem_re), 32'h1);
    chk("resume_addr", 32'(mem_addr), 32'h000E);
    $display("wrap line: fill to 16, resume at 000E after one pop");

    // Host writes while fetch is satisfied: one grant per two cycles
    wr_req  = 1'b1;
    wr_addr = 16'h1234;
    wr_data = 8'hA5;
    tick();
    chk("wr1_we", 32'(mem_we), 32'h1);
    chk("wr1_ack", 32'(wr_ack), 32'h1);
    chk("wr1_addr", 32'(mem_addr), 32'h1234);
    chk("wr1_data", 32'(mem_wdata), 32'hA5);
    chk("wr1_re", 32'(mem_re), 32'h0);
    tick();
    chk("wr2_we", 32'(mem_we), 32'h0);
    chk("wr2_ack", 32'(wr_ack), 32'h0);
    tick();
    chk("wr3_we", 32'(mem_we), 32'h1);
    chk("wr3_ack", 32'(wr_ack), 32'h1);
    wr_req = 1'b0;
    tick();
    chk("wr4_we", 32'(mem_we), 32'h0);
    $display("host write 1234/A5 granted every other cycle");

    // Below low water, reads pre-empt a pending write
    start_line(16'h2040);
    chk("pre_flush_valid", 32'(pix_valid), 32'h0);
    wr_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("pre_re", 32'(mem_re), 32'h1);
      chk("pre_we", 32'(mem_we), 32'h0);
      if (k == 3) chk("pre_head", 32'(pix_data), 32'h40);
    end
    tick();
    chk("pre_wr_we", 32'(mem_we), 32'h1);
    chk("pre_wr_ack", 32'(wr_ack), 32'h1);
    chk("pre_wr_re", 32'(mem_re), 32'h0);
    wr_req = 1'b0;
    tick();
    chk("pre_next_re", 32'(mem_re), 32'h1);
    chk("pre_next_addr", 32'(mem_addr), 32'h2048);
    $display("low-water priority: 8 reads before the write");

    // Restart mid-line while a read is in flight
    start_line(16'h0300);
    tick(); tick(); tick();
    pix_rd = 1'b1;
    for (int i = 0; i < 300; i++) begin
      chk("l3_pop_data", 32'(pix_data), 32'(i % 256));
      tick();
    end
    chk("l3_inflight", 32'(mem_re), 32'h1);
    pix_rd = 1'b0;
    start_line(16'h0580);
    chk("rs_e0_valid", 32'(pix_valid), 32'h0);
    chk("rs_e0_re", 32'(mem_re), 32'h0);
    tick();
    chk("rs_e1_re", 32'(mem_re), 32'h1);
    chk("rs_e1_addr", 32'(mem_addr), 32'h0580);
    tick();
    chk("rs_e2_valid", 32'(pix_valid), 32'h0);
    tick();
    chk("rs_e3_valid", 32'(pix_valid), 32'h1);
    chk("rs_e3_data", 32'(pix_data), 32'h80);
    chk("rs_underrun", 32'(underrun), 32'h0);
    $display("restart at word 300: first word 80 from base 0580");

    // Reset mid-line stops all strobes at once
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_re", 32'(mem_re), 32'h0);
    chk("arst_valid", 32'(pix_valid), 32'h0);
    chk("arst_addr", 32'(mem_addr), 32'h0);
    tick();
    chk("arst_re_hold", 32'(mem_re), 32'h0);
    $display("async reset mid-line");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
